rsa_ctrl: RTL and testbench
===========================

RSA_CTRL -- requirements
Module: rsa_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 256, operand width in bits; a multiple of 8 and at least 16.
REQ-002 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  input byte valid.
REQ-005 SHALL have port in_data  input  8  input byte, MSB-first within each word.
REQ-006 SHALL have port in_ready  output  1  controller accepts a byte this cycle.
REQ-007 SHALL have port out_valid  output  1  output byte valid.
REQ-008 SHALL have port out_data  output  8  output byte.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the byte.
REQ-010 SHALL have ports key_e and key_n  input  NBITS each  exponent and modulus; sampled in every cycle that pow_start is high.
REQ-011 SHALL have port pow_start  output  1  one-cycle start pulse to the Power core.
REQ-012 SHALL have ports pow_a1, pow_a2, pow_a3  output  NBITS each  base (assembled word), key_e, key_n.
REQ-013 SHALL have port pow_done  input  1  Power core result valid.
REQ-014 SHALL have port pow_a0  input  NBITS  Power core result (a1^a2 mod a3).

Function
REQ-015 SHALL implement the FSM states RECV, START, WAIT, SEND and, when REQ-031 applies, CSUM.
REQ-016 In RECV, SHALL drive in_ready=1; in all other states, SHALL drive in_ready=0.
REQ-017 A byte SHALL transfer only in a cycle with in_valid=1 and in_ready=1; each transfer SHALL shift the byte into the LSB of the base register (word = (word<<8)|in_data) and increment the byte counter.
REQ-018 On the transfer with byte counter = NBITS/8-1, the counter SHALL wrap to 0 and the FSM SHALL go to START.
REQ-019 In START, SHALL drive pow_start=1 for exactly one cycle with pow_a1, pow_a2 and pow_a3 valid, then go to WAIT. pow_start SHALL be high in the cycle immediately after the last byte transfer.
REQ-020 pow_a1, pow_a2 and pow_a3 SHALL remain stable from START until the FSM leaves WAIT.
REQ-021 In WAIT, when pow_done=1 is sampled, SHALL register pow_a0 and go to SEND, with out_valid=1 on the next cycle.
REQ-022 pow_done SHALL be ignored in every state except WAIT.
REQ-023 In SEND, SHALL present the result bytes MSB-first, starting with pow_a0[NBITS-1:NBITS-8].
REQ-024 A byte SHALL advance only when out_valid=1 and out_ready=1; while out_ready=0, out_data and out_valid SHALL hold.
REQ-025 After the final byte transfers, SHALL go to CSUM (REQ-031) or to RECV, and SHALL assert in_ready in the following cycle.
REQ-026 out_valid SHALL be 0 in every state except SEND and CSUM.
REQ-027 SHALL process one word at a time: there is no overlap between receiving and sending.

Reset
REQ-028 When rst=1 at an edge, SHALL set: state RECV, counters 0, base register 0, result register 0, pow_start 0, out_valid 0, out_data 0. in_ready SHALL be 1 in the cycle after reset.
REQ-029 Reset in any state (mid-receive, WAIT, mid-send) SHALL discard the partial word and pending result; a pow_done arriving later SHALL be ignored.
REQ-030 Reset SHALL take priority over every simultaneous event.

Configuration
REQ-031 With macro RSA_CTRL_CHKSUM_EN defined, SHALL compute the XOR of all result bytes sent and emit it as one extra byte in CSUM, using the same handshake, before returning to RECV.
REQ-032 Without RSA_CTRL_CHKSUM_EN, CSUM and its logic SHALL NOT exist, and SEND SHALL go directly to RECV.

Verification
REQ-033 Reset check: assert rst for 2 cycles, then release -> all outputs 0 except in_ready=1.
REQ-034 Receive check: send bytes 0x00..0x1F back-to-back (NBITS=256) -> pow_a1=0x000102...1F; pow_start high for exactly 1 cycle, in the cycle after byte 0x1F; in_ready=0 until the result is sent.
REQ-035 Send with backpressure: pow_done=1 with pow_a0={32{8'hAA}}, out_ready toggling 1/0 -> 32 bytes of 0xAA, each held while out_ready=0, then in_ready=1.
REQ-036 Spurious done: pulse pow_done during RECV after 5 bytes -> no state change; the remaining 27 bytes still produce one pow_start.
REQ-037 Mid-receive reset: assert rst after 10 bytes, then send 32 bytes 0xFF -> pow_a1 = all ones, exactly one pow_start.
REQ-038 Checksum check (RSA_CTRL_CHKSUM_EN defined): pow_a0 bytes 0x01..0x20 -> 33 bytes out, the last = 0x20; with the macro undefined -> exactly 32 bytes out.

Source files
------------

// File: rtl/rsa_ctrl.sv
// Byte-serial front end for an RSA Power core: collects an NBITS word, launches the core, streams the result back.
// Optional macro RSA_CTRL_CHKSUM_EN appends an XOR checksum byte after each result word.
module rsa_ctrl #(
    parameter int NBITS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    input  logic [NBITS-1:0] key_e,
    input  logic [NBITS-1:0] key_n,
    output logic             pow_start,
    output logic [NBITS-1:0] pow_a1,
    output logic [NBITS-1:0] pow_a2,
    output logic [NBITS-1:0] pow_a3,
    input  logic             pow_done,
    input  logic [NBITS-1:0] pow_a0
);

    localparam int NBYTES = NBITS / 8;
    localparam int CW = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

`ifdef RSA_CTRL_CHKSUM_EN
    typedef enum logic [2:0] {RECV, START, WAIT, SEND, CSUM} state_t;
`else
    typedef enum logic [1:0] {RECV, START, WAIT, SEND} state_t;
`endif

    state_t           state_q, state_d;
    logic [NBITS-1:0] base_q, base_d;
    logic [NBITS-1:0] result_q, result_d;
    logic [NBITS-1:0] e_q, e_d;
    logic [NBITS-1:0] n_q, n_d;
    logic [CW-1:0]    rcnt_q, rcnt_d;
    logic [CW-1:0]    ocnt_q, ocnt_d;
    logic [7:0]       txByte;
`ifdef RSA_CTRL_CHKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    assign txByte = result_q[NBITS-1 -: 8];
    assign pow_a1 = base_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RECV;
            base_q   <= '0;
            result_q <= '0;
            e_q      <= '0;
            n_q      <= '0;
            rcnt_q   <= '0;
            ocnt_q   <= '0;
`ifdef RSA_CTRL_CHKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            result_q <= result_d;
            e_q      <= e_d;
            n_q      <= n_d;
            rcnt_q   <= rcnt_d;
            ocnt_q   <= ocnt_d;
`ifdef RSA_CTRL_CHKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        result_d  = result_q;
        e_d       = e_q;
        n_d       = n_q;
        rcnt_d    = rcnt_q;
        ocnt_d    = ocnt_q;
`ifdef RSA_CTRL_CHKSUM_EN
        csum_d    = csum_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        pow_start = 1'b0;
        // Keys pass straight through while starting, then come from the copy taken that cycle.
        pow_a2    = (state_q == START) ? key_e : e_q;
        pow_a3    = (state_q == START) ? key_n : n_q;

        case (state_q)
            RECV: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    base_d = {base_q[NBITS-9:0], in_data};
                    if (rcnt_q == LAST) begin
                        rcnt_d  = '0;
                        state_d = START;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            START: begin
                pow_start = 1'b1;
                e_d       = key_e;
                n_d       = key_n;
                state_d   = WAIT;
            end
            WAIT: begin
                if (pow_done) begin
                    result_d = pow_a0;
                    ocnt_d   = '0;
`ifdef RSA_CTRL_CHKSUM_EN
                    csum_d   = 8'h00;
`endif
                    state_d  = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = txByte;
                // The result register shifts left so the next byte is always in the top slot.
                if (out_ready) begin
                    result_d = {result_q[NBITS-9:0], 8'h00};
`ifdef RSA_CTRL_CHKSUM_EN
                    csum_d   = csum_q ^ txByte;
`endif
                    if (ocnt_q == LAST) begin
                        ocnt_d  = '0;
`ifdef RSA_CTRL_CHKSUM_EN
                        state_d = CSUM;
`else
                        state_d = RECV;
`endif
                    end else begin
                        ocnt_d = ocnt_q + 1'b1;
                    end
                end
            end
`ifdef RSA_CTRL_CHKSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_q;
                if (out_ready) begin
                    state_d = RECV;
                end
            end
`endif
            default: begin
                state_d = RECV;
            end
        endcase
    end

endmodule

// File: tb/tb_rsa_ctrl.sv
// Directed self-checking bench for rsa_ctrl at NBITS=256; follows RSA_CTRL_CHKSUM_EN for the expected byte count.
module tb_rsa_ctrl;

    localparam int NBITS = 256;
    localparam int NBYTES = NBITS / 8;
`ifdef RSA_CTRL_CHKSUM_EN
    localparam int EXP_BYTES = NBYTES + 1;
`else
    localparam int EXP_BYTES = NBYTES;
`endif
    localparam logic [NBITS-1:0] KEY_E  = 256'h10001;
    localparam logic [NBITS-1:0] KEY_E2 = 256'h3;
    localparam logic [NBITS-1:0] KEY_N  = {8{32'hC0FFEE11}};
    localparam logic [NBITS-1:0] SEQ_00_1F =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [NBITS-1:0] SEQ_01_20 =
        256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;

    typedef struct {
        logic [NBITS-1:0] inWord;
        logic [NBITS-1:0] result;
        bit               backpressure;
        logic [NBITS-1:0] expA1;
        logic [7:0]       expCsum;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    logic [NBITS-1:0] key_e;
    logic [NBITS-1:0] key_n;
    logic             pow_start;
    logic [NBITS-1:0] pow_a1;
    logic [NBITS-1:0] pow_a2;
    logic [NBITS-1:0] pow_a3;
    logic             pow_done;
    logic [NBITS-1:0] pow_a0;

    int testsRun = 0;
    int failures = 0;
    int startCount = 0;
    vec_t vecs[3];

    rsa_ctrl #(.NBITS(NBITS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .key_e(key_e), .key_n(key_n),
        .pow_start(pow_start), .pow_a1(pow_a1), .pow_a2(pow_a2), .pow_a3(pow_a3),
        .pow_done(pow_done), .pow_a0(pow_a0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (pow_start) startCount++;
    end

    task automatic checkOutput(input string name, input logic [NBITS-1:0] actual,
                               input logic [NBITS-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic sendBytes(input logic [NBITS-1:0] word, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = word[NBITS-1-8*i -: 8];
            checkOutput("inReadyRecv", in_ready, 1);
        end
    endtask

    // Call right after the last byte was driven; leaves the DUT in WAIT at a falling edge.
    task automatic checkStart(input logic [NBITS-1:0] expA1, input int startBase);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("powStartHigh", pow_start, 1);
        checkOutput("powA1", pow_a1, expA1);
        checkOutput("powA2Start", pow_a2, KEY_E);
        checkOutput("powA3Start", pow_a3, KEY_N);
        checkOutput("inReadyStart", in_ready, 0);
        @(negedge clk);
        key_e = KEY_E2;
        checkOutput("powStartLow", pow_start, 0);
        checkOutput("startPulses", startCount - startBase, 1);
        checkOutput("inReadyWait", in_ready, 0);
        checkOutput("powA1Held", pow_a1, expA1);
        checkOutput("powA2Held", pow_a2, KEY_E);
    endtask

    task automatic finishResult(input logic [NBITS-1:0] result, input bit bp,
                                input logic [7:0] csum);
        int idx;
        int cyc;
        bit phase;
        logic [7:0] expByte;
        repeat (2) begin
            @(negedge clk);
            checkOutput("outValidWait", out_valid, 0);
            checkOutput("powA3Held", pow_a3, KEY_N);
        end
        @(negedge clk);
        pow_done = 1'b1;
        pow_a0   = result;
        @(negedge clk);
        pow_done = 1'b0;
        pow_a0   = '0;
        key_e    = KEY_E;
        idx = 0;
        cyc = 0;
        phase = !bp;
        while (idx < EXP_BYTES && cyc < 200) begin
            expByte = (idx < NBYTES) ? result[NBITS-1-8*idx -: 8] : csum;
            checkOutput("outValidSend", out_valid, 1);
            checkOutput("outData", out_data, expByte);
            checkOutput("inReadySend", in_ready, 0);
            out_ready = phase;
            if (phase) idx++;
            if (bp) phase = !phase;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checkOutput("sendInBudget", cyc < 200, 1);
        checkOutput("outValidDone", out_valid, 0);
        checkOutput("inReadyDone", in_ready, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int s0;
        s0 = startCount;
        sendBytes(v.inWord, 0, NBYTES - 1);
        checkStart(v.expA1, s0);
        finishResult(v.result, v.backpressure, v.expCsum);
    endtask

    initial begin
        int s0;
        vecs[0] = '{inWord: SEQ_00_1F, result: {32{8'hAA}}, backpressure: 1'b1,
                    expA1: SEQ_00_1F, expCsum: 8'h00};
        vecs[1] = '{inWord: {NBITS{1'b1}}, result: SEQ_01_20, backpressure: 1'b0,
                    expA1: {NBITS{1'b1}}, expCsum: 8'h20};
        vecs[2] = '{inWord: {8{32'hDEADBEEF}}, result: {8'h80, 248'h0}, backpressure: 1'b1,
                    expA1: {8{32'hDEADBEEF}}, expCsum: 8'h80};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        key_e = KEY_E;
        key_n = KEY_N;
        pow_done = 1'b0;
        pow_a0 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstInReady", in_ready, 1);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstOutData", out_data, 0);
        checkOutput("rstPowStart", pow_start, 0);
        checkOutput("rstPowA1", pow_a1, 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i]);
        end

        // Spurious done in RECV after 5 bytes must not disturb the word.
        s0 = startCount;
        sendBytes(SEQ_00_1F, 0, 4);
        @(negedge clk);
        in_valid = 1'b0;
        pow_done = 1'b1;
        pow_a0   = {32{8'h77}};
        @(negedge clk);
        pow_done = 1'b0;
        pow_a0   = '0;
        checkOutput("spurInReady", in_ready, 1);
        checkOutput("spurOutValid", out_valid, 0);
        checkOutput("spurNoStart", startCount - s0, 0);
        sendBytes(SEQ_00_1F, 5, NBYTES - 1);
        checkStart(SEQ_00_1F, s0);
        finishResult({32{8'h11}}, 1'b0, 8'h00);

        // Reset while waiting: a late done must not produce output.
        sendBytes(SEQ_00_1F, 0, NBYTES - 1);
        checkStart(SEQ_00_1F, startCount);
        key_e = KEY_E;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("waitRstInReady", in_ready, 1);
        @(negedge clk);
        pow_done = 1'b1;
        pow_a0   = {32{8'hAA}};
        @(negedge clk);
        pow_done = 1'b0;
        pow_a0   = '0;
        checkOutput("lateDoneOutValid", out_valid, 0);
        checkOutput("lateDoneInReady", in_ready, 1);

        // Reset after 10 bytes, then a full all-ones word.
        sendBytes({32{8'h55}}, 0, 9);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstPowA1", pow_a1, 0);
        s0 = startCount;
        sendBytes({NBITS{1'b1}}, 0, NBYTES - 1);
        checkStart({NBITS{1'b1}}, s0);
        finishResult({32{8'h5A}}, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
